// File: rtl/im_sync_mem.sv
// im_sync_mem: synchronous-read instruction memory for the MIPS fetch stage.
// It provides a registered fetch with a request/valid handshake, a program-load
// write port, an optional walk-clear of the memory after reset, a pipeline
// hold, and detection of misaligned and out-of-range fetches.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   fetch_req    fetch request
//   fetch_addr   byte address of the instruction (ADDR_W bits)
//   fetch_ready  fetch can be accepted this cycle (combinational)
//   hold         pipeline stall; freezes inst_out/inst_valid/inst_err
//   inst_out     fetched instruction (registered)
//   inst_valid   inst_out belongs to a request accepted at the last edge
//   inst_err     that request was misaligned or out of range
//   load_we      program-load write strobe (honoured only in READY)
//   load_idx     word index to write
//   load_data    word to write
//   init_done    clear finished; memory usable
module im_sync_mem #(
  parameter int unsigned       DATA_W         = 32,
  parameter int unsigned       ADDR_W         = 12,
  parameter int unsigned       DEPTH          = 1024,
  parameter int unsigned       IDX_W          = $clog2(DEPTH),
  parameter bit                CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] FILL_WORD      = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  input  logic              hold,
  output logic [DATA_W-1:0] inst_out,
  output logic              inst_valid,
  output logic              inst_err,
  input  logic              load_we,
  input  logic [IDX_W-1:0]  load_idx,
  input  logic [DATA_W-1:0] load_data,
  output logic              init_done
);

  typedef enum logic {
    INIT,
    READY
  } state_t;

  localparam state_t RST_STATE = CLEAR_ON_RESET ? INIT : READY;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-3:0] f_idx;
  logic [IDX_W-1:0]  f_widx;
  logic              misaligned;
  logic              oor;
  logic              bad_addr;
  logic              accept;
  logic              load_ok;
  logic              collide;
  logic [DATA_W-1:0] rd_word;

  assign f_idx      = fetch_addr[ADDR_W-1:2];
  assign f_widx     = f_idx[IDX_W-1:0];
  assign misaligned = |fetch_addr[1:0];
  assign oor        = (32'(f_idx) >= DEPTH);
  assign bad_addr   = misaligned | oor;

  assign fetch_ready = (state_q == READY) && !hold;
  assign accept      = fetch_req && fetch_ready;
  assign init_done   = (state_q == READY);

  // Loads land only in READY and only for indices inside the array; an
  // out-of-range index must not alias onto a lower word.
  assign load_ok = (state_q == READY) && load_we && (32'(load_idx) < DEPTH);

  // Write-first: a load to the word being fetched in the same cycle is
  // forwarded, since the array read below still sees the old contents.
  assign collide = load_ok && (load_idx == f_widx);
  assign rd_word = collide ? load_data : mem_q[f_widx];

  // Memory array has no reset so it can map onto block RAM; contents persist
  // across rst unless the INIT walk overwrites them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == INIT) begin
        mem_q[cnt_q] <= FILL_WORD;
      end else if (load_ok) begin
        mem_q[load_idx] <= load_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    err_d   = err_q;

    case (state_q)
      INIT: begin
        cnt_d = cnt_q + IDX_W'(1);
        if (cnt_q == IDX_W'(DEPTH - 1)) begin
          state_d = READY;
          cnt_d   = '0;
        end
      end
      READY:   state_d = READY;
      default: state_d = RST_STATE;
    endcase

    if (!hold) begin
      valid_d = accept;
      err_d   = accept && bad_addr;
      if (accept) begin
        inst_d = bad_addr ? FILL_WORD : rd_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      inst_q  <= FILL_WORD;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign inst_out   = inst_q;
  assign inst_valid = valid_q;
  assign inst_err   = err_q;

endmodule

// File: tb/tb_im_sync_mem.sv
// Directed testbench for im_sync_mem. Instance a: DEPTH=1024 with reset clear.
// Instance b: DEPTH=1000 without reset clear (range checks, persistence).
module tb_im_sync_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance a
  logic        a_rst = 1'b1, a_req = 1'b0, a_hold = 1'b0, a_we = 1'b0;
  logic [11:0] a_addr = '0;
  logic [9:0]  a_li = '0;
  logic [31:0] a_ld = '0;
  logic        a_rdy, a_val, a_err, a_done;
  logic [31:0] a_out;

  // instance b
  logic        b_rst = 1'b1, b_req = 1'b0, b_hold = 1'b0, b_we = 1'b0;
  logic [11:0] b_addr = '0;
  logic [9:0]  b_li = '0;
  logic [31:0] b_ld = '0;
  logic        b_rdy, b_val, b_err, b_done;
  logic [31:0] b_out;

  int total = 0;
  int bad   = 0;

  im_sync_mem #(.DATA_W(32), .ADDR_W(12), .DEPTH(1024), .CLEAR_ON_RESET(1'b1),
                .FILL_WORD(32'h0000_0000)) dut_a (
    .clk(clk), .rst(a_rst), .fetch_req(a_req), .fetch_addr(a_addr),
    .fetch_ready(a_rdy), .hold(a_hold), .inst_out(a_out), .inst_valid(a_val),
    .inst_err(a_err), .load_we(a_we), .load_idx(a_li), .load_data(a_ld),
    .init_done(a_done)
  );

  im_sync_mem #(.DATA_W(32), .ADDR_W(12), .DEPTH(1000), .CLEAR_ON_RESET(1'b0),
                .FILL_WORD(32'h0000_0000)) dut_b (
    .clk(clk), .rst(b_rst), .fetch_req(b_req), .fetch_addr(b_addr),
    .fetch_ready(b_rdy), .hold(b_hold), .inst_out(b_out), .inst_valid(b_val),
    .inst_err(b_err), .load_we(b_we), .load_idx(b_li), .load_data(b_ld),
    .init_done(b_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_cyc(input logic req, input logic [11:0] addr, input logic we,
                       input logic [9:0] li, input logic [31:0] ld);
    a_req = req; a_addr = addr; a_we = we; a_li = li; a_ld = ld;
    tick();
    a_req = 1'b0; a_we = 1'b0;
  endtask

  task automatic b_cyc(input logic req, input logic [11:0] addr, input logic we,
                       input logic [9:0] li, input logic [31:0] ld);
    b_req = req; b_addr = addr; b_we = we; b_li = li; b_ld = ld;
    tick();
    b_req = 1'b0; b_we = 1'b0;
  endtask

  // Counts cycles from reset release until init_done; bounded.
  task automatic a_wait_init(output int n, output int rdy_bad);
    n = 0;
    rdy_bad = 0;
    while (a_done !== 1'b1 && n < 3000) begin
      if (a_rdy !== 1'b0) rdy_bad++;
      tick();
      n++;
    end
  endtask

  int n, rb;

  initial begin
    // ---------------- instance b: DEPTH=1000, no clear ----------------
    tick();
    b_rst = 1'b0;
    check_eq("b_rst_done", 32'(b_done), 32'd1);
    check_eq("b_rst_rdy", 32'(b_rdy), 32'd1);
    check_eq("b_rst_val", 32'(b_val), 32'd0);
    check_eq("b_rst_out", b_out, 32'h0);

    b_cyc(1'b0, 12'h000, 1'b1, 10'd0,    32'hAAAA_0000);
    b_cyc(1'b0, 12'h000, 1'b1, 10'd999,  32'hBBBB_0999);
    b_cyc(1'b0, 12'h000, 1'b1, 10'd1000, 32'hDEAD_BEEF);

    b_cyc(1'b1, 12'h000, 1'b0, 10'd0, 32'h0);
    check_eq("b_w0_out", b_out, 32'hAAAA_0000);
    check_eq("b_w0_val", 32'(b_val), 32'd1);
    b_cyc(1'b1, 12'hF9C, 1'b0, 10'd0, 32'h0);
    check_eq("b_w999_out", b_out, 32'hBBBB_0999);
    check_eq("b_w999_err", 32'(b_err), 32'd0);
    b_cyc(1'b1, 12'hFA0, 1'b0, 10'd0, 32'h0);
    check_eq("b_oor_err", 32'(b_err), 32'd1);
    check_eq("b_oor_out", b_out, 32'h0);
    check_eq("b_oor_val", 32'(b_val), 32'd1);

    b_rst = 1'b1;
    b_cyc(1'b1, 12'hF9C, 1'b0, 10'd0, 32'h0);
    check_eq("b_rstfetch_val", 32'(b_val), 32'd0);
    check_eq("b_rst_done2", 32'(b_done), 32'd1);
    b_rst = 1'b0;
    b_cyc(1'b1, 12'hF9C, 1'b0, 10'd0, 32'h0);
    check_eq("b_persist", b_out, 32'hBBBB_0999);

    // ---------------- instance a: DEPTH=1024, clear on reset ----------------
    tick();
    check_eq("a_rst_val", 32'(a_val), 32'd0);
    check_eq("a_rst_err", 32'(a_err), 32'd0);
    check_eq("a_rst_out", a_out, 32'h0);
    check_eq("a_rst_done", 32'(a_done), 32'd0);
    check_eq("a_rst_rdy", 32'(a_rdy), 32'd0);
    a_rst = 1'b0;
    // request and a load held high through INIT: both must be ignored
    a_req = 1'b1; a_addr = 12'h000;
    a_we = 1'b1; a_li = 10'd0; a_ld = 32'hFFFF_FFFF;
    a_wait_init(n, rb);
    a_req = 1'b0; a_we = 1'b0;
    check_eq("a_init_len", 32'(n), 32'd1024);
    check_eq("a_init_rdy", 32'(rb), 32'd0);
    check_eq("a_init_val", 32'(a_val), 32'd0);

    a_cyc(1'b1, 12'h000, 1'b0, 10'd0, 32'h0);
    check_eq("a_clr_w0", a_out, 32'h0);
    check_eq("a_clr_w0_val", 32'(a_val), 32'd1);
    a_cyc(1'b1, 12'hFFC, 1'b0, 10'd0, 32'h0);
    check_eq("a_top_err", 32'(a_err), 32'd0);
    check_eq("a_top_val", 32'(a_val), 32'd1);

    a_cyc(1'b0, 12'h000, 1'b1, 10'd1, 32'h2011_0001);
    check_eq("a_idle_val", 32'(a_val), 32'd0);
    a_cyc(1'b1, 12'h004, 1'b0, 10'd0, 32'h0);
    check_eq("a_ld_out", a_out, 32'h2011_0001);
    check_eq("a_ld_val", 32'(a_val), 32'd1);
    check_eq("a_ld_err", 32'(a_err), 32'd0);
    a_cyc(1'b0, 12'h000, 1'b0, 10'd0, 32'h0);
    check_eq("a_keep_out", a_out, 32'h2011_0001);
    check_eq("a_keep_val", 32'(a_val), 32'd0);

    a_cyc(1'b0, 12'h000, 1'b1, 10'd0, 32'h2010_0000);
    a_cyc(1'b0, 12'h000, 1'b1, 10'd2, 32'h2012_0002);
    a_cyc(1'b1, 12'h000, 1'b0, 10'd0, 32'h0);
    check_eq("a_b2b0_out", a_out, 32'h2010_0000);
    check_eq("a_b2b0_val", 32'(a_val), 32'd1);
    a_cyc(1'b1, 12'h004, 1'b0, 10'd0, 32'h0);
    check_eq("a_b2b1_out", a_out, 32'h2011_0001);
    check_eq("a_b2b1_val", 32'(a_val), 32'd1);

    a_cyc(1'b1, 12'h006, 1'b0, 10'd0, 32'h0);
    check_eq("a_mis_err", 32'(a_err), 32'd1);
    check_eq("a_mis_out", a_out, 32'h0);
    check_eq("a_mis_val", 32'(a_val), 32'd1);

    a_cyc(1'b1, 12'h014, 1'b1, 10'd5, 32'h0800_0C05);
    check_eq("a_coll_out", a_out, 32'h0800_0C05);
    a_cyc(1'b1, 12'h014, 1'b0, 10'd0, 32'h0);
    check_eq("a_coll_mem", a_out, 32'h0800_0C05);

    // hold: result frozen, pending request waits, load still lands
    a_cyc(1'b1, 12'h008, 1'b0, 10'd0, 32'h0);
    check_eq("a_pre_hold", a_out, 32'h2012_0002);
    a_hold = 1'b1; a_req = 1'b1; a_addr = 12'h004;
    a_we = 1'b1; a_li = 10'd3; a_ld = 32'h1111_1111;
    #1;
    check_eq("a_hold_rdy", 32'(a_rdy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      a_we = 1'b0;
      check_eq("a_hold_out", a_out, 32'h2012_0002);
      check_eq("a_hold_val", 32'(a_val), 32'd1);
      check_eq("a_hold_err", 32'(a_err), 32'd0);
    end
    a_hold = 1'b0;
    tick();
    a_req = 1'b0;
    check_eq("a_rel_out", a_out, 32'h2011_0001);
    check_eq("a_rel_val", 32'(a_val), 32'd1);
    a_cyc(1'b1, 12'h00C, 1'b0, 10'd0, 32'h0);
    check_eq("a_hold_load", a_out, 32'h1111_1111);

    // reset with a fetch in flight, then reset again mid-INIT
    a_rst = 1'b1;
    a_cyc(1'b1, 12'h000, 1'b0, 10'd0, 32'h0);
    check_eq("a_rstf_val", 32'(a_val), 32'd0);
    check_eq("a_rstf_out", a_out, 32'h0);
    check_eq("a_rstf_done", 32'(a_done), 32'd0);
    a_rst = 1'b0;
    for (int i = 0; i < 500; i++) tick();
    check_eq("a_mid_done", 32'(a_done), 32'd0);
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0;
    a_wait_init(n, rb);
    check_eq("a_reinit_len", 32'(n), 32'd1024);
    check_eq("a_reinit_rdy", 32'(rb), 32'd0);
    a_cyc(1'b1, 12'h004, 1'b0, 10'd0, 32'h0);
    check_eq("a_recleared", a_out, 32'h0);
    check_eq("a_recleared_val", 32'(a_val), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
